cio_uart_bridge: RTL

//  Console I/O stage beside DekatronPC: consumes the Cout strobe plus BCD Data and transmits one UART byte.

---
 rtl/dpc_io_pkg.sv | 34 +++
 rtl/cio_uart_rx.sv | 96 +++++++++
 rtl/cio_uart_bridge.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/dpc_io_pkg.sv
// Shared constants, FSM state types and BCD/byte conversions for the
// DekatronPC console I/O bridge.
package dpc_io_pkg;

   localparam int DEKATRON_WIDTH    = 4;
   localparam int DATA_DEKATRON_NUM = 3;
   localparam int BCD_W             = DEKATRON_WIDTH * DATA_DEKATRON_NUM;

   typedef enum logic [2:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_STOP,
      TX_ACK
   } tx_state_t;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_t;

   // Weighted digit sum folded to a byte; digits above 9 are not clamped.
   function automatic logic [7:0] bcd3_to_byte(input logic [BCD_W-1:0] d);
      return 8'(16'(d[11:8]) * 16'd100 + 16'(d[7:4]) * 16'd10 + 16'(d[3:0]));
   endfunction

   // Byte split into hundreds/tens/units, 0..255 -> 000..255.
   function automatic logic [BCD_W-1:0] byte_to_bcd3(input logic [7:0] b);
      return {4'(b / 8'd100), 4'((b % 8'd100) / 8'd10), 4'(b % 8'd10)};
   endfunction

endpackage

// File: rtl/cio_uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, start-bit re-check at half bit,
// centre sampling, stop-bit validation. Emits a one-cycle o_valid per byte.
module cio_uart_rx #(
   parameter int CLKS_PER_BIT = 104
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_rx,
   output logic [7:0] o_byte,
   output logic       o_valid
);
   import dpc_io_pkg::*;

   localparam int            CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF     = CW'(CLKS_PER_BIT / 2 - 1);

   logic          r_sync1, r_sync2, r_prev;
   rx_state_t     r_state;
   logic [CW-1:0] r_cnt;
   logic [2:0]    r_bit;
   logic [7:0]    r_shift;
   logic [7:0]    r_byte;
   logic          r_valid;
   logic          w_fall;

   assign w_fall  = r_prev & ~r_sync2;
   assign o_byte  = r_byte;
   assign o_valid = r_valid;

   // Bring the asynchronous line into Clk and keep one extra tap for edge detect.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
         r_prev  <= 1'b1;
      end else begin
         r_sync1 <= i_rx;
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
      end
   end

   // Frame FSM: a bad start returns to idle, a bad stop silently drops the byte.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= RX_IDLE;
         r_cnt   <= '0;
         r_bit   <= '0;
         r_shift <= '0;
         r_byte  <= '0;
         r_valid <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         case (r_state)
            RX_IDLE: begin
               r_cnt <= '0;
               if (w_fall) r_state <= RX_START;
            end
            RX_START: begin
               if (r_cnt == HALF) begin
                  r_cnt   <= '0;
                  r_bit   <= '0;
                  r_state <= r_sync2 ? RX_IDLE : RX_DATA;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            RX_DATA: begin
               if (r_cnt == BIT_LAST) begin
                  r_cnt   <= '0;
                  r_shift <= {r_sync2, r_shift[7:1]};
                  if (r_bit == 3'd7) r_state <= RX_STOP;
                  else               r_bit   <= r_bit + 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            RX_STOP: begin
               if (r_cnt == BIT_LAST) begin
                  r_cnt   <= '0;
                  r_state <= RX_IDLE;
                  if (r_sync2) begin
                     r_byte  <= r_shift;
                     r_valid <= 1'b1;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: r_state <= RX_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/cio_uart_bridge.sv
// DekatronPC console bridge: Cout prints one BCD cell as a UART byte,
// CinReq returns the last received byte as BCD, both completed by CioAcq.
module cio_uart_bridge #(
   parameter int DEKATRON_WIDTH    = dpc_io_pkg::DEKATRON_WIDTH,
   parameter int DATA_DEKATRON_NUM = dpc_io_pkg::DATA_DEKATRON_NUM,
   parameter int CLKS_PER_BIT      = 104
) (
   input  logic                                        Clk,
   input  logic                                        Rst_n,
   input  logic                                        Cout,
   input  logic                                        CinReq,
   input  logic [DEKATRON_WIDTH*DATA_DEKATRON_NUM-1:0] Data,
   output logic [DEKATRON_WIDTH*DATA_DEKATRON_NUM-1:0] DataCin,
   output logic                                        CioAcq,
   output logic                                        uart_tx,
   input  logic                                        uart_rx,
   output logic                                        tx_busy,
   output logic                                        rx_overrun
);
   import dpc_io_pkg::*;

   localparam int            DW       = DEKATRON_WIDTH * DATA_DEKATRON_NUM;
   localparam int            CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);

   tx_state_t     r_tx_state;
   logic [CW-1:0] r_tx_cnt;
   logic [2:0]    r_tx_bit;
   logic [7:0]    r_tx_shift;
   logic          r_tx, r_busy;
   logic          r_tx_go, r_cin_pend;
   logic          r_acq, r_acq_d;
   logic          r_buf_vld, r_overrun;
   logic [7:0]    r_buf;
   logic [DW-1:0] r_data_cin;
   logic [7:0]    w_rx_byte;
   logic          w_rx_vld;
   logic          w_free, w_take_tx, w_take_cin, w_read;

   cio_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
      .i_clk   (Clk),
      .i_rst_n (Rst_n),
      .i_rx    (uart_rx),
      .o_byte  (w_rx_byte),
      .o_valid (w_rx_vld)
   );

   // New requests only when nothing is in flight and no ack in the last two
   // cycles, so a level still held after its ack is never served again.
   assign w_free     = (r_tx_state == TX_IDLE) && !r_tx_go && !r_cin_pend && !r_acq && !r_acq_d;
   assign w_take_tx  = w_free && Cout;
   assign w_take_cin = w_free && !Cout && CinReq;
   assign w_read     = r_buf_vld && (w_take_cin || r_cin_pend);

   assign DataCin    = r_data_cin;
   assign CioAcq     = r_acq;
   assign uart_tx    = r_tx;
   assign tx_busy    = r_busy;
   assign rx_overrun = r_overrun;

   // Arbiter: grant output one cycle ahead of the frame, park input requests until a byte lands.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_tx_go    <= 1'b0;
         r_cin_pend <= 1'b0;
      end else begin
         r_tx_go <= w_take_tx;
         if (w_take_cin && !r_buf_vld) r_cin_pend <= 1'b1;
         else if (w_read)              r_cin_pend <= 1'b0;
      end
   end

   // TX FSM with registered line and busy outputs; line idles high.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_tx_state <= TX_IDLE;
         r_tx_cnt   <= '0;
         r_tx_bit   <= '0;
         r_tx_shift <= '0;
         r_tx       <= 1'b1;
         r_busy     <= 1'b0;
      end else begin
         case (r_tx_state)
            TX_IDLE: begin
               r_tx <= 1'b1;
               if (r_tx_go) begin
                  r_tx_shift <= bcd3_to_byte(Data);
                  r_tx_cnt   <= '0;
                  r_tx       <= 1'b0;
                  r_busy     <= 1'b1;
                  r_tx_state <= TX_START;
               end
            end
            TX_START: begin
               if (r_tx_cnt == BIT_LAST) begin
                  r_tx_cnt   <= '0;
                  r_tx_bit   <= '0;
                  r_tx       <= r_tx_shift[0];
                  r_tx_state <= TX_DATA;
               end else begin
                  r_tx_cnt <= r_tx_cnt + 1'b1;
               end
            end
            TX_DATA: begin
               if (r_tx_cnt == BIT_LAST) begin
                  r_tx_cnt <= '0;
                  if (r_tx_bit == 3'd7) begin
                     r_tx       <= 1'b1;
                     r_tx_state <= TX_STOP;
                  end else begin
                     r_tx       <= r_tx_shift[1];
                     r_tx_shift <= r_tx_shift >> 1;
                     r_tx_bit   <= r_tx_bit + 1'b1;
                  end
               end else begin
                  r_tx_cnt <= r_tx_cnt + 1'b1;
               end
            end
            TX_STOP: begin
               if (r_tx_cnt == BIT_LAST) begin
                  r_tx_cnt   <= '0;
                  r_busy     <= 1'b0;
                  r_tx_state <= TX_ACK;
               end else begin
                  r_tx_cnt <= r_tx_cnt + 1'b1;
               end
            end
            TX_ACK:  r_tx_state <= TX_IDLE;
            default: r_tx_state <= TX_IDLE;
         endcase
      end
   end

   // Ack pulse, input service and the 1-deep buffer flags; a same-cycle read takes the old byte.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_acq      <= 1'b0;
         r_acq_d    <= 1'b0;
         r_buf_vld  <= 1'b0;
         r_overrun  <= 1'b0;
         r_data_cin <= '0;
      end else begin
         r_acq   <= w_read || (r_tx_state == TX_ACK);
         r_acq_d <= r_acq;
         if (w_read) r_data_cin <= DW'(byte_to_bcd3(r_buf));
         if (w_rx_vld) begin
            r_buf_vld <= 1'b1;
            if (r_buf_vld && !w_read) r_overrun <= 1'b1;
         end else if (w_read) begin
            r_buf_vld <= 1'b0;
         end
      end
   end

   // Buffer payload; validity is tracked separately so no reset is needed here.
   always_ff @(posedge Clk) begin
      if (w_rx_vld) r_buf <= w_rx_byte;
   end

endmodule
